// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: divides clk_in down to a pixel-rate enable and
// produces registered sync, blanking and coordinate outputs.
module vga_sync_gen #(
  parameter int DIV       = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33
) (
  input  logic       clk_in,
  input  logic       rst,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic [9:0] pixel_x,
  output logic [9:0] pixel_y,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int PW      = (DIV > 2) ? $clog2(DIV) : 1;

  localparam logic [PW-1:0] P_MAX  = PW'(DIV - 1);
  localparam logic [9:0]    H_MAX  = 10'(H_TOTAL - 1);
  localparam logic [9:0]    V_MAX  = 10'(V_TOTAL - 1);
  localparam logic [9:0]    H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0]    V_VIS  = 10'(V_VISIBLE);
  localparam logic [10:0]   HS_BEG = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0]   HS_END = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0]   VS_BEG = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0]   VS_END = 11'(V_VISIBLE + V_FP + V_SYNC);

  logic [PW-1:0] p;
  logic [9:0]    h_cnt, v_cnt;
  logic [9:0]    h_nxt, v_nxt;
  logic          adv, h_wrap;

  always_comb begin
    adv    = (p == P_MAX);
    h_wrap = (h_cnt == H_MAX);
    h_nxt  = h_wrap ? 10'd0 : h_cnt + 10'd1;
    v_nxt  = v_cnt;
    if (h_wrap) v_nxt = (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
  end

  // Outputs load the decode of the next counter state, so they move on the
  // advance edge together with the counters and never glitch in between.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      p           <= '0;
      h_cnt       <= H_MAX;
      v_cnt       <= V_MAX;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      video_on    <= 1'b0;
      pixel_tick  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      p           <= adv ? '0 : p + 1'b1;
      pixel_tick  <= adv;
      frame_start <= adv && (h_nxt == 10'd0) && (v_nxt == 10'd0);
      if (adv) begin
        h_cnt    <= h_nxt;
        v_cnt    <= v_nxt;
        hsync    <= !(({1'b0, h_nxt} >= HS_BEG) && ({1'b0, h_nxt} < HS_END));
        vsync    <= !(({1'b0, v_nxt} >= VS_BEG) && ({1'b0, v_nxt} < VS_END));
        video_on <= (h_nxt < H_VIS) && (v_nxt < V_VIS);
      end
    end
  end

  assign pixel_x = h_cnt;
  assign pixel_y = v_cnt;

endmodule
